// File: rtl/pmem_arbiter.sv
// -----------------------------------------------------------------------------
// pmem_arbiter
//
// Shares the single physical-memory port between the I-cache and D-cache miss
// paths. One requester is granted at a time and keeps the grant until the
// memory answers with pmem_resp (or until it withdraws its request). After
// every grant the arbiter spends one cycle in IDLE, so a requester has a cycle
// to drop its request before it could be granted again.
//
// Conflict policy:
//   FIXED_PRI = 0 : round-robin, the source that was not granted last wins.
//   FIXED_PRI = 1 : the D-cache always wins a conflict.
//
// Optional build macro: PMEM_ARB_PERF_COUNT_EN
//   defined   : 16-bit saturating grant counters (I read, D read, D write)
//               with a synchronous clear.
//   undefined : no counter flops; counter outputs read 0, counters_clear is
//               ignored. Arbitration is identical in both builds.
//
// Ports:
//   clk, reset_n                  clock (rising edge), async active-low reset
//   i_pmem_*                      I-cache side (read only)
//   d_pmem_*                      D-cache side (read or writeback)
//   pmem_*                        physical memory side
//   counters_clear                synchronous clear of all counters
//   i_read_miss, d_read_miss,
//   d_write_miss                  grant counters
// -----------------------------------------------------------------------------
module pmem_arbiter #(
    parameter int          ADDR_WIDTH = 16,
    parameter int          LINE_WIDTH = 128,
    parameter int unsigned FIXED_PRI  = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,

    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,

    input  logic                  counters_clear,
    output logic [15:0]           i_read_miss,
    output logic [15:0]           d_read_miss,
    output logic [15:0]           d_write_miss
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t state_reg, state_next;
    // 0 = I-cache was granted last, 1 = D-cache was granted last
    logic   last_grant_reg, last_grant_next;

    logic i_req;
    logic d_req;
    logic conflict_pick_d;
    logic grant_i;
    logic grant_d;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    // On a conflict: fixed priority always picks D; round-robin picks D only
    // when I was the last one served.
    assign conflict_pick_d = (FIXED_PRI != 0) || (last_grant_reg == 1'b0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
        end
    end

    // Next state and all outputs. Outputs are a pure function of the state
    // register and live inputs, so an async reset drops the memory command
    // without waiting for a clock edge.
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        grant_i         = 1'b0;
        grant_d         = 1'b0;
        pmem_read       = 1'b0;
        pmem_write      = 1'b0;
        pmem_address    = '0;
        pmem_wdata      = '0;
        i_pmem_resp     = 1'b0;
        i_pmem_rdata    = '0;
        d_pmem_resp     = 1'b0;
        d_pmem_rdata    = '0;

        case (state_reg)
            IDLE: begin
                // pmem_resp is deliberately ignored here.
                if (i_req && d_req) begin
                    grant_d = conflict_pick_d;
                    grant_i = !conflict_pick_d;
                end else begin
                    grant_d = d_req;
                    grant_i = i_req;
                end
                if (grant_d) begin
                    state_next      = SERVE_D;
                    last_grant_next = 1'b1;
                end else if (grant_i) begin
                    state_next      = SERVE_I;
                    last_grant_next = 1'b0;
                end
            end

            SERVE_I: begin
                if (!i_req) begin
                    // Withdrawn request: command already low, abort.
                    state_next = IDLE;
                end else begin
                    pmem_read    = 1'b1;
                    pmem_address = i_pmem_address;
                    if (pmem_resp) begin
                        i_pmem_resp  = 1'b1;
                        i_pmem_rdata = pmem_rdata;
                        state_next   = IDLE;
                    end
                end
            end

            SERVE_D: begin
                if (!d_req) begin
                    state_next = IDLE;
                end else begin
                    // Read+write together is illegal; the write wins.
                    pmem_write   = d_pmem_write;
                    pmem_read    = d_pmem_read & ~d_pmem_write;
                    pmem_address = d_pmem_address;
                    pmem_wdata   = d_pmem_wdata;
                    if (pmem_resp) begin
                        d_pmem_resp  = 1'b1;
                        d_pmem_rdata = pmem_rdata;
                        state_next   = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef PMEM_ARB_PERF_COUNT_EN
    // Counter index: 0 = I read, 1 = D read, 2 = D write.
    logic [2:0]  cnt_inc;
    logic [15:0] cnt_val [3];

    assign cnt_inc[0] = grant_i;
    assign cnt_inc[1] = grant_d & d_pmem_read & ~d_pmem_write;
    assign cnt_inc[2] = grant_d & d_pmem_write;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : gen_cnt
            logic [15:0] cnt_reg;
            logic [15:0] cnt_next;

            // Clear beats a same-cycle increment; counters stick at all-ones.
            always_comb begin
                cnt_next = cnt_reg;
                if (counters_clear) begin
                    cnt_next = '0;
                end else if (cnt_inc[gi] && (cnt_reg != 16'hFFFF)) begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    assign i_read_miss  = cnt_val[0];
    assign d_read_miss  = cnt_val[1];
    assign d_write_miss = cnt_val[2];
`else
    assign i_read_miss  = 16'h0;
    assign d_read_miss  = 16'h0;
    assign d_write_miss = 16'h0;

    // Grant strobes and the clear input only feed the counters.
    logic unused_cnt_inputs;
    assign unused_cnt_inputs = ^{counters_clear, grant_i, grant_d};
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pmem_arbiter
//
// Directed bench for pmem_arbiter. dut0 is the round-robin build, dut1 the
// fixed-priority build; both share every input. Counter expectations follow
// the PMEM_ARB_PERF_COUNT_EN build macro (counters read 0 when it is absent).
// -----------------------------------------------------------------------------
module tb_pmem_arbiter;

`ifdef PMEM_ARB_PERF_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [127:0] RDATA_A5 = {16{8'hA5}};
    localparam logic [127:0] WDATA_1  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] WDATA_2  = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         i_pmem_read, d_pmem_read, d_pmem_write, pmem_resp, counters_clear;
    logic [15:0]  i_pmem_address, d_pmem_address;
    logic [127:0] d_pmem_wdata, pmem_rdata;

    logic [127:0] o0_i_rdata, o0_d_rdata, o0_wdata, o1_i_rdata, o1_d_rdata, o1_wdata;
    logic         o0_i_resp, o0_d_resp, o0_read, o0_write;
    logic         o1_i_resp, o1_d_resp, o1_read, o1_write;
    logic [15:0]  o0_addr, o0_i_cnt, o0_dr_cnt, o0_dw_cnt;
    logic [15:0]  o1_addr, o1_i_cnt, o1_dr_cnt, o1_dw_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_i = 16'h0, exp_dr = 16'h0, exp_dw = 16'h0;

    always #5 clk = ~clk;

    pmem_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128), .FIXED_PRI(0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(o0_i_rdata), .i_pmem_resp(o0_i_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(o0_d_rdata), .d_pmem_resp(o0_d_resp),
        .pmem_read(o0_read), .pmem_write(o0_write), .pmem_address(o0_addr),
        .pmem_wdata(o0_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .counters_clear(counters_clear), .i_read_miss(o0_i_cnt),
        .d_read_miss(o0_dr_cnt), .d_write_miss(o0_dw_cnt)
    );

    pmem_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128), .FIXED_PRI(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(o1_i_rdata), .i_pmem_resp(o1_i_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(o1_d_rdata), .d_pmem_resp(o1_d_resp),
        .pmem_read(o1_read), .pmem_write(o1_write), .pmem_address(o1_addr),
        .pmem_wdata(o1_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .counters_clear(counters_clear), .i_read_miss(o1_i_cnt),
        .d_read_miss(o1_dr_cnt), .d_write_miss(o1_dw_cnt)
    );

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (!CNT_EN) return 16'h0;
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        i_pmem_read = 1'b1; d_pmem_write = 1'b1; pmem_resp = 1'b1;
        pmem_rdata = RDATA_A5; i_pmem_address = 16'h1111; d_pmem_address = 16'h2222;
        d_pmem_wdata = WDATA_1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({o0_read, o0_write, o0_i_resp, o0_d_resp} !== 4'b0) begin
            n_bad++; $display("FAIL reset.cmd got %b want 0000", {o0_read, o0_write, o0_i_resp, o0_d_resp});
        end
        n_cmp++;
        if (o0_addr !== 16'h0 || o0_wdata !== 128'h0) begin
            n_bad++; $display("FAIL reset.addr_wdata got %h/%h want 0/0", o0_addr, o0_wdata);
        end
        n_cmp++;
        if (o0_i_rdata !== 128'h0 || o0_d_rdata !== 128'h0) begin
            n_bad++; $display("FAIL reset.rdata got %h/%h want 0/0", o0_i_rdata, o0_d_rdata);
        end
        n_cmp++;
        if ({o0_i_cnt, o0_dr_cnt, o0_dw_cnt} !== 48'h0) begin
            n_bad++; $display("FAIL reset.counters got %h/%h/%h want 0", o0_i_cnt, o0_dr_cnt, o0_dw_cnt);
        end
        i_pmem_read = 1'b0; d_pmem_write = 1'b0; pmem_resp = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({o0_read, o0_write} !== 2'b00) begin
            n_bad++; $display("FAIL reset.idle_after got %b want 00", {o0_read, o0_write});
        end
        $display("txn reset: released, arbiter idle");
    endtask

    task automatic test_single_i();
        @(negedge clk);
        i_pmem_address = 16'h1240; i_pmem_read = 1'b1;
        #1;
        n_cmp++;
        if (o0_read !== 1'b0) begin
            n_bad++; $display("FAIL single_i.latency got %b want 0", o0_read);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (o0_read !== 1'b1 || o0_write !== 1'b0 || o0_addr !== 16'h1240 || o0_wdata !== 128'h0) begin
            n_bad++; $display("FAIL single_i.cmd got r%b w%b a%h wd%h want r1 w0 a1240 wd0", o0_read, o0_write, o0_addr, o0_wdata);
        end
        pmem_rdata = RDATA_A5; pmem_resp = 1'b1;
        #1;
        n_cmp++;
        if (o0_i_resp !== 1'b1 || o0_i_rdata !== RDATA_A5) begin
            n_bad++; $display("FAIL single_i.resp got %b %h want 1 %h", o0_i_resp, o0_i_rdata, RDATA_A5);
        end
        n_cmp++;
        if (o0_d_resp !== 1'b0 || o0_d_rdata !== 128'h0) begin
            n_bad++; $display("FAIL single_i.d_quiet got %b %h want 0 0", o0_d_resp, o0_d_rdata);
        end
        @(negedge clk);
        i_pmem_read = 1'b0; pmem_resp = 1'b0;
        #1;
        exp_i = sat_inc(exp_i);
        n_cmp++;
        if (o0_i_cnt !== exp_i || o0_read !== 1'b0) begin
            n_bad++; $display("FAIL single_i.count got cnt%h r%b want cnt%h r0", o0_i_cnt, o0_read, exp_i);
        end
        $display("txn single_i: read 1240 served");
    endtask

    task automatic test_conflict_rr();
        @(negedge clk);
        i_pmem_address = 16'h1240; i_pmem_read = 1'b1;
        d_pmem_address = 16'h2000; d_pmem_wdata = WDATA_1; d_pmem_write = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if (o0_write !== 1'b1 || o0_read !== 1'b0 || o0_addr !== 16'h2000 || o0_wdata !== WDATA_1) begin
            n_bad++; $display("FAIL conflict_rr.d_first got w%b r%b a%h wd%h want w1 r0 a2000 wd%h", o0_write, o0_read, o0_addr, o0_wdata, WDATA_1);
        end
        pmem_resp = 1'b1;
        #1;
        n_cmp++;
        if (o0_d_resp !== 1'b1 || o0_i_resp !== 1'b0 || o0_i_rdata !== 128'h0) begin
            n_bad++; $display("FAIL conflict_rr.d_resp got d%b i%b irdata%h want d1 i0 irdata0", o0_d_resp, o0_i_resp, o0_i_rdata);
        end
        @(negedge clk);
        d_pmem_write = 1'b0; pmem_resp = 1'b0;
        #1;
        n_cmp++;
        if ({o0_read, o0_write} !== 2'b00) begin
            n_bad++; $display("FAIL conflict_rr.dead_cycle got %b want 00", {o0_read, o0_write});
        end
        @(negedge clk); #1;
        n_cmp++;
        if (o0_read !== 1'b1 || o0_addr !== 16'h1240 || o0_wdata !== 128'h0) begin
            n_bad++; $display("FAIL conflict_rr.i_second got r%b a%h wd%h want r1 a1240 wd0", o0_read, o0_addr, o0_wdata);
        end
        pmem_resp = 1'b1;
        #1;
        n_cmp++;
        if (o0_i_resp !== 1'b1) begin
            n_bad++; $display("FAIL conflict_rr.i_resp got %b want 1", o0_i_resp);
        end
        @(negedge clk);
        i_pmem_read = 1'b0; pmem_resp = 1'b0;
        #1;
        exp_i = sat_inc(exp_i); exp_dw = sat_inc(exp_dw);
        n_cmp++;
        if (o0_i_cnt !== exp_i || o0_dw_cnt !== exp_dw) begin
            n_bad++; $display("FAIL conflict_rr.count got i%h dw%h want i%h dw%h", o0_i_cnt, o0_dw_cnt, exp_i, exp_dw);
        end
        $display("txn conflict_rr: D write 2000 then I read 1240");
    endtask

    task automatic test_dual_rw();
        @(negedge clk);
        d_pmem_address = 16'h3000; d_pmem_wdata = WDATA_2;
        d_pmem_read = 1'b1; d_pmem_write = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if (o0_write !== 1'b1 || o0_read !== 1'b0 || o0_wdata !== WDATA_2) begin
            n_bad++; $display("FAIL dual_rw.cmd got w%b r%b wd%h want w1 r0 wd%h", o0_write, o0_read, o0_wdata, WDATA_2);
        end
        pmem_resp = 1'b1;
        #1;
        n_cmp++;
        if (o0_d_resp !== 1'b1) begin
            n_bad++; $display("FAIL dual_rw.resp got %b want 1", o0_d_resp);
        end
        @(negedge clk);
        d_pmem_read = 1'b0; d_pmem_write = 1'b0; pmem_resp = 1'b0;
        #1;
        exp_dw = sat_inc(exp_dw);
        n_cmp++;
        if (o0_dw_cnt !== exp_dw || o0_dr_cnt !== exp_dr) begin
            n_bad++; $display("FAIL dual_rw.count got dw%h dr%h want dw%h dr%h", o0_dw_cnt, o0_dr_cnt, exp_dw, exp_dr);
        end
        $display("txn dual_rw: D read+write 3000 treated as write");
    endtask

    task automatic test_rr_i_wins();
        // Last grant was D, so round-robin must hand the conflict to I.
        @(negedge clk);
        i_pmem_address = 16'h1300; i_pmem_read = 1'b1;
        d_pmem_address = 16'h4000; d_pmem_read = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if (o0_read !== 1'b1 || o0_addr !== 16'h1300) begin
            n_bad++; $display("FAIL rr_i_wins.i_first got r%b a%h want r1 a1300", o0_read, o0_addr);
        end
        pmem_resp = 1'b1;
        #1;
        n_cmp++;
        if (o0_i_resp !== 1'b1 || o0_d_resp !== 1'b0 || o0_d_rdata !== 128'h0) begin
            n_bad++; $display("FAIL rr_i_wins.i_resp got i%b d%b drdata%h want i1 d0 drdata0", o0_i_resp, o0_d_resp, o0_d_rdata);
        end
        @(negedge clk);
        i_pmem_read = 1'b0; pmem_resp = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if (o0_read !== 1'b1 || o0_addr !== 16'h4000) begin
            n_bad++; $display("FAIL rr_i_wins.d_second got r%b a%h want r1 a4000", o0_read, o0_addr);
        end
        pmem_resp = 1'b1;
        #1;
        n_cmp++;
        if (o0_d_resp !== 1'b1 || o0_d_rdata !== RDATA_A5) begin
            n_bad++; $display("FAIL rr_i_wins.d_resp got %b %h want 1 %h", o0_d_resp, o0_d_rdata, RDATA_A5);
        end
        @(negedge clk);
        d_pmem_read = 1'b0; pmem_resp = 1'b0;
        #1;
        exp_i = sat_inc(exp_i); exp_dr = sat_inc(exp_dr);
        n_cmp++;
        if (o0_i_cnt !== exp_i || o0_dr_cnt !== exp_dr) begin
            n_bad++; $display("FAIL rr_i_wins.count got i%h dr%h want i%h dr%h", o0_i_cnt, o0_dr_cnt, exp_i, exp_dr);
        end
        $display("txn rr_i_wins: I read 1300 then D read 4000");
    endtask

    task automatic test_abort_idle_resp();
        @(negedge clk);
        pmem_resp = 1'b1;
        #1;
        n_cmp++;
        if ({o0_i_resp, o0_d_resp, o0_read, o0_write} !== 4'b0) begin
            n_bad++; $display("FAIL abort.idle_resp got %b want 0000", {o0_i_resp, o0_d_resp, o0_read, o0_write});
        end
        @(negedge clk);
        pmem_resp = 1'b0; d_pmem_address = 16'h5000; d_pmem_read = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if (o0_read !== 1'b1 || o0_addr !== 16'h5000) begin
            n_bad++; $display("FAIL abort.granted got r%b a%h want r1 a5000", o0_read, o0_addr);
        end
        d_pmem_read = 1'b0;
        #1;
        n_cmp++;
        if (o0_read !== 1'b0) begin
            n_bad++; $display("FAIL abort.cmd_drop got %b want 0", o0_read);
        end
        @(negedge clk);
        i_pmem_address = 16'h1400; i_pmem_read = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if (o0_read !== 1'b1 || o0_addr !== 16'h1400) begin
            n_bad++; $display("FAIL abort.next_grant got r%b a%h want r1 a1400", o0_read, o0_addr);
        end
        pmem_resp = 1'b1;
        @(negedge clk);
        i_pmem_read = 1'b0; pmem_resp = 1'b0;
        #1;
        exp_dr = sat_inc(exp_dr); exp_i = sat_inc(exp_i);
        n_cmp++;
        if (o0_dr_cnt !== exp_dr || o0_i_cnt !== exp_i) begin
            n_bad++; $display("FAIL abort.count got dr%h i%h want dr%h i%h", o0_dr_cnt, o0_i_cnt, exp_dr, exp_i);
        end
        $display("txn abort: D read 5000 withdrawn, I read 1400 served");
    endtask

    task automatic test_saturation();
`ifdef PMEM_ARB_PERF_COUNT_EN
        @(negedge clk);
        dut0.gen_cnt[0].cnt_reg = 16'hFFFE;
        exp_i = 16'hFFFE;
`endif
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            i_pmem_address = 16'h1500; i_pmem_read = 1'b1;
            @(negedge clk);
            pmem_resp = 1'b1;
            @(negedge clk);
            i_pmem_read = 1'b0; pmem_resp = 1'b0;
            #1;
            exp_i = sat_inc(exp_i);
            n_cmp++;
            if (o0_i_cnt !== exp_i) begin
                n_bad++; $display("FAIL saturation.grant%0d got %h want %h", k, o0_i_cnt, exp_i);
            end
            $display("txn saturation: I grant %0d, i_read_miss=%h", k, o0_i_cnt);
        end
        @(negedge clk);
        i_pmem_read = 1'b1; counters_clear = 1'b1;
        @(negedge clk);
        counters_clear = 1'b0; pmem_resp = 1'b1;
        #1;
        exp_i = 16'h0; exp_dr = 16'h0; exp_dw = 16'h0;
        n_cmp++;
        if ({o0_i_cnt, o0_dr_cnt, o0_dw_cnt} !== 48'h0) begin
            n_bad++; $display("FAIL saturation.clear_on_grant got %h/%h/%h want 0", o0_i_cnt, o0_dr_cnt, o0_dw_cnt);
        end
        @(negedge clk);
        i_pmem_read = 1'b0; pmem_resp = 1'b0;
        $display("txn saturation: clear on grant edge");
    endtask

    task automatic test_fixed_pri();
        logic [15:0] f_i  = 16'h0;
        logic [15:0] f_dw = 16'h0;
        logic [15:0] d_addr;
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        exp_i = 16'h0; exp_dr = 16'h0; exp_dw = 16'h0;
        @(negedge clk);
        d_addr = 16'h6000;
        i_pmem_address = 16'h1600; i_pmem_read = 1'b1;
        d_pmem_address = d_addr; d_pmem_wdata = WDATA_1; d_pmem_write = 1'b1;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (o1_write !== 1'b1 || o1_read !== 1'b0 || o1_addr !== d_addr) begin
                n_bad++; $display("FAIL fixed_pri.d_round%0d got w%b r%b a%h want w1 r0 a%h", r, o1_write, o1_read, o1_addr, d_addr);
            end
            pmem_resp = 1'b1;
            #1;
            n_cmp++;
            if (o1_d_resp !== 1'b1 || o1_i_resp !== 1'b0) begin
                n_bad++; $display("FAIL fixed_pri.resp_round%0d got d%b i%b want d1 i0", r, o1_d_resp, o1_i_resp);
            end
            f_dw = sat_inc(f_dw);
            $display("txn fixed_pri: D write %h round %0d", d_addr, r);
            @(negedge clk);
            pmem_resp = 1'b0;
            d_addr = d_addr + 16'h0010;
            if (r < 2) d_pmem_address = d_addr;
            else d_pmem_write = 1'b0;
        end
        @(negedge clk); #1;
        n_cmp++;
        if (o1_read !== 1'b1 || o1_addr !== 16'h1600) begin
            n_bad++; $display("FAIL fixed_pri.i_last got r%b a%h want r1 a1600", o1_read, o1_addr);
        end
        pmem_resp = 1'b1;
        @(negedge clk);
        i_pmem_read = 1'b0; pmem_resp = 1'b0;
        #1;
        f_i = sat_inc(f_i);
        n_cmp++;
        if (o1_dw_cnt !== f_dw || o1_i_cnt !== f_i) begin
            n_bad++; $display("FAIL fixed_pri.count got dw%h i%h want dw%h i%h", o1_dw_cnt, o1_i_cnt, f_dw, f_i);
        end
        $display("txn fixed_pri: I read 1600 served after D idle");
    endtask

    task automatic test_async_reset();
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        exp_i = 16'h0; exp_dr = 16'h0; exp_dw = 16'h0;
        @(negedge clk);
        d_pmem_address = 16'h7000; d_pmem_wdata = WDATA_2; d_pmem_write = 1'b1;
        @(negedge clk); #1;
        exp_dw = sat_inc(exp_dw);
        n_cmp++;
        if (o0_write !== 1'b1 || o0_dw_cnt !== exp_dw) begin
            n_bad++; $display("FAIL async_reset.serving got w%b dw%h want w1 dw%h", o0_write, o0_dw_cnt, exp_dw);
        end
        #1 reset_n = 1'b0;
        #1;
        exp_dw = 16'h0;
        n_cmp++;
        if (o0_write !== 1'b0 || o0_wdata !== 128'h0) begin
            n_bad++; $display("FAIL async_reset.cmd_drop got w%b wd%h want w0 wd0", o0_write, o0_wdata);
        end
        n_cmp++;
        if ({o0_i_cnt, o0_dr_cnt, o0_dw_cnt} !== 48'h0) begin
            n_bad++; $display("FAIL async_reset.counters got %h/%h/%h want 0", o0_i_cnt, o0_dr_cnt, o0_dw_cnt);
        end
        @(negedge clk);
        reset_n = 1'b1; d_pmem_write = 1'b0;
        i_pmem_address = 16'h1700; i_pmem_read = 1'b1;
        #1;
        n_cmp++;
        if ({o0_read, o0_write} !== 2'b00) begin
            n_bad++; $display("FAIL async_reset.idle got %b want 00", {o0_read, o0_write});
        end
        @(negedge clk); #1;
        n_cmp++;
        if (o0_read !== 1'b1 || o0_addr !== 16'h1700) begin
            n_bad++; $display("FAIL async_reset.new_grant got r%b a%h want r1 a1700", o0_read, o0_addr);
        end
        pmem_resp = 1'b1;
        #1;
        n_cmp++;
        if (o0_i_resp !== 1'b1) begin
            n_bad++; $display("FAIL async_reset.i_resp got %b want 1", o0_i_resp);
        end
        @(negedge clk);
        i_pmem_read = 1'b0; pmem_resp = 1'b0;
        #1;
        exp_i = sat_inc(exp_i);
        n_cmp++;
        if (o0_i_cnt !== exp_i) begin
            n_bad++; $display("FAIL async_reset.count got %h want %h", o0_i_cnt, exp_i);
        end
        $display("txn async_reset: D write aborted by reset, I read 1700 served");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
        pmem_resp = 1'b0; counters_clear = 1'b0;
        i_pmem_address = 16'h0; d_pmem_address = 16'h0;
        d_pmem_wdata = 128'h0; pmem_rdata = 128'h0;

        test_reset();
        test_single_i();
        test_conflict_rr();
        test_dual_rw();
        test_rr_i_wins();
        test_abort_idle_resp();
        test_saturation();
        test_fixed_pri();
        test_async_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
